scan_seq8: RTL and testbench
============================

Name: scan_seq8

Overview:
- Row-scan sequencer for an 8-row multiplexed LED/segment matrix.
- Produces the 3-bit row index consumed by the team's 3-to-8 row decoder, plus a row-enable gate and column data.
- Column data comes from a double-buffered 8x8 frame store.
- Host writes the back buffer and requests a swap, which occurs only at a frame boundary (tear-free).

Parameters:
PRESCALE, 4, clock cycles each row is driven (DRIVE phase), must be >= 1
BLANK, 1, dead cycles before each row with row_en=0 and col_data=0 (anti-ghosting), must be >= 1

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  scan enable (level)
wr_en  in  1  back-buffer write strobe
wr_addr  in  3  row address for write
wr_data  in  8  column pattern for that row
swap_req  in  1  request front/back swap (single-cycle pulse or level; latched)
row_sel  out  3  current row index, to 3-to-8 decoder input
row_en  out  1  high only in DRIVE phase; gates decoder outputs
col_data  out  8  front-buffer pattern of row_sel during DRIVE, else 0
frame_done  out  1  one-cycle pulse at end of row 7 DRIVE
swap_ack  out  1  one-cycle pulse when swap is performed

Behaviour:
- All outputs registered.
- Reset, synchronous: state=IDLE, row_sel=0, row_en=0, col_data=0, frame_done=0, swap_ack=0, phase counter=0, swap_pending=0, front select=buffer 0, both buffers cleared to 0x00.
- Reset mid-scan aborts immediately; there is no partial-frame completion.
- States:
  - IDLE: row_en=0, col_data=0, row_sel=0. Enters BLANK on the first edge where en=1.
  - BLANK: lasts exactly BLANK cycles; row_en=0, col_data=0. Then enters DRIVE.
  - DRIVE: lasts exactly PRESCALE cycles. row_en=1 and col_data=front[row_sel], both asserted on the same edge.
  - DRIVE contents are re-read every cycle, so a swap becomes visible only at the next frame's first row.
- End of DRIVE, i.e. the last DRIVE cycle's edge:
  - If row_sel=7: row_sel wraps to 0 and frame_done pulses.
  - Otherwise: row_sel increments.
  - Next state is BLANK if en=1, else IDLE with row_sel=0.
- en deasserted mid-row: the current row completes its phases, then the block returns to IDLE. en is ignored until that row ends.
- Timing:
  - en sampled high at edge k: first row_en=1 visible after edge k+BLANK.
  - Row period = BLANK+PRESCALE.
  - Frame period = 8*(BLANK+PRESCALE).
- Swap:
  - swap_pending is set by swap_req and cleared when the swap executes.
  - Swap executes on the frame_done edge if (swap_pending | swap_req) in that cycle. swap_ack pulses coincident with frame_done.
  - Multiple requests within one frame collapse to one swap.
  - No swap ever occurs while in IDLE. A pending request persists until the next frame boundary.
- Writes:
  - wr_en writes wr_data into the back buffer at wr_addr, visible the next cycle.
  - A write in the swap cycle lands in the pre-swap back buffer. It therefore appears in the new front buffer.
  - The front buffer is never writable.
- Counter: phase counter width = clog2(max(BLANK,PRESCALE)+1). It resets to 0 at every phase change.

Decomposition:
- Shared package scan_pkg holds:
  - state enum {IDLE, BLANK, DRIVE}
  - NROWS=8
  - ROW_W=3
  - COL_W=8
- Sub-module scan_fbuf: 2x8x8 register file with write port to the back buffer, combinational read of the front buffer, and a swap input toggling the front select.
- Top-level contains the FSM, phase counter and output registers.

Test Plan:
- Reset with en=1, PRESCALE=4, BLANK=1 -> all outputs 0 during reset. First row_en=1 one cycle after the en edge with row_sel=0. row_sel walks 0..7, each row_en high 4 cycles and low 1 cycle. frame_done at cycle 40.
- Write rows 0..7 = 0x01,0x02,...,0x80 with no swap -> col_data stays 0x00 (front buffer). Pulse swap_req at cycle 10 -> swap_ack+frame_done at frame end. Next frame shows col_data 0x01..0x80 on rows 0..7.
- swap_req asserted exactly in the frame_done cycle -> swap happens that cycle. Three swap_reqs within one frame -> exactly one swap_ack.
- Drop en during row 3 DRIVE cycle 2 -> row 3 completes its remaining DRIVE cycles, then IDLE with row_sel=0 and row_en=0. Re-raise en -> restart at row 0 after BLANK.
- Assert rst during row 5 DRIVE -> next cycle row_en=0, col_data=0, row_sel=0, buffers read 0x00 after a swap.
- BLANK=3, PRESCALE=1 -> each row is 3 cycles low and 1 cycle high. frame_done every 32 cycles. row_en is never high while row_sel changes.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and sizes for the 8-row matrix scan sequencer.
package scan_pkg;

    localparam int NROWS = 8;
    localparam int ROW_W = 3;
    localparam int COL_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/scan_fbuf.sv
// Double-buffered 8x8 frame store: host writes the back buffer, the
// scanner reads the front buffer, and a swap flips which is which.
module scan_fbuf
    import scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [ROW_W-1:0] wr_addr,
    input  logic [COL_W-1:0] wr_data,
    input  logic             swap,
    input  logic [ROW_W-1:0] rd_addr,
    output logic [COL_W-1:0] rd_data
);

    logic [COL_W-1:0] mem_q [2][NROWS];
    logic             front_q;

    // Back-buffer write uses the pre-swap select, so a write in the swap
    // cycle ends up in the new front buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            front_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < NROWS; r++) begin
                    mem_q[b][r] <= '0;
                end
            end
        end else begin
            if (wr_en) begin
                mem_q[~front_q][wr_addr] <= wr_data;
            end
            if (swap) begin
                front_q <= ~front_q;
            end
        end
    end

    assign rd_data = mem_q[front_q][rd_addr];

endmodule

// File: rtl/scan_seq8.sv
// Row-scan sequencer: BLANK/DRIVE phase timing per row, row index and
// column data outputs, and tear-free front/back swap at frame end.
module scan_seq8
    import scan_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int BLANK    = 1
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr_en,
    input  logic [ROW_W-1:0] wr_addr,
    input  logic [COL_W-1:0] wr_data,
    input  logic             swap_req,
    output logic [ROW_W-1:0] row_sel,
    output logic             row_en,
    output logic [COL_W-1:0] col_data,
    output logic             frame_done,
    output logic             swap_ack
);

    localparam int CNT_W = $clog2(max_int(BLANK, PRESCALE) + 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(NROWS - 1);

    scan_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ROW_W-1:0] row_sel_q;
    logic             row_en_q;
    logic [COL_W-1:0] col_data_q;
    logic             frame_done_q;
    logic             swap_ack_q;
    logic             swap_pending_q;

    logic             drive_end;
    logic             swap_fire;
    logic [COL_W-1:0] front_row;

    assign drive_end = (state_q == ST_DRIVE) && (cnt_q == DRIVE_LAST);
    assign swap_fire = drive_end && (row_sel_q == LAST_ROW) &&
                       (swap_pending_q || swap_req);

    scan_fbuf u_fbuf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .swap    (swap_fire),
        .rd_addr (row_sel_q),
        .rd_data (front_row)
    );

    // Scan FSM with phase counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            row_sel_q      <= '0;
            row_en_q       <= 1'b0;
            col_data_q     <= '0;
            frame_done_q   <= 1'b0;
            swap_ack_q     <= 1'b0;
            swap_pending_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            swap_ack_q   <= 1'b0;
            if (swap_fire) begin
                swap_pending_q <= 1'b0;
            end else if (swap_req) begin
                swap_pending_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    cnt_q      <= '0;
                    row_sel_q  <= '0;
                    row_en_q   <= 1'b0;
                    col_data_q <= '0;
                    state_q    <= en ? ST_BLANK : ST_IDLE;
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_q    <= ST_DRIVE;
                        cnt_q      <= '0;
                        row_en_q   <= 1'b1;
                        col_data_q <= front_row;
                    end else begin
                        cnt_q      <= cnt_q + CNT_W'(1);
                        row_en_q   <= 1'b0;
                        col_data_q <= '0;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == DRIVE_LAST) begin
                        // en is only honoured here, once the row has finished.
                        cnt_q        <= '0;
                        row_en_q     <= 1'b0;
                        col_data_q   <= '0;
                        frame_done_q <= (row_sel_q == LAST_ROW);
                        swap_ack_q   <= swap_fire;
                        if (en) begin
                            state_q   <= ST_BLANK;
                            row_sel_q <= row_sel_q + ROW_W'(1);
                        end else begin
                            state_q   <= ST_IDLE;
                            row_sel_q <= '0;
                        end
                    end else begin
                        cnt_q      <= cnt_q + CNT_W'(1);
                        row_en_q   <= 1'b1;
                        col_data_q <= front_row;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    cnt_q      <= '0;
                    row_sel_q  <= '0;
                    row_en_q   <= 1'b0;
                    col_data_q <= '0;
                end
            endcase
        end
    end

    assign row_sel    = row_sel_q;
    assign row_en     = row_en_q;
    assign col_data   = col_data_q;
    assign frame_done = frame_done_q;
    assign swap_ack   = swap_ack_q;

endmodule

// File: tb/tb_scan_seq8.sv
// Bench for scan_seq8: two instances (PRESCALE=4/BLANK=1 and PRESCALE=1/BLANK=3)
// checked every cycle against a frame-position reference model.
module tb_scan_seq8;

    logic       clk = 1'b0;
    logic       rst, en, wr_en, swap_req;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;

    logic [2:0] rs_a, rs_b;
    logic       re_a, re_b, fd_a, fd_b, sa_a, sa_b;
    logic [7:0] cd_a, cd_b;
    logic [13:0] obs_a, obs_b;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    scan_seq8 #(.PRESCALE(4), .BLANK(1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .swap_req(swap_req), .row_sel(rs_a), .row_en(re_a),
        .col_data(cd_a), .frame_done(fd_a), .swap_ack(sa_a));

    scan_seq8 #(.PRESCALE(1), .BLANK(3)) dut_b (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .swap_req(swap_req), .row_sel(rs_b), .row_en(re_b),
        .col_data(cd_b), .frame_done(fd_b), .swap_ack(sa_b));

    assign obs_a = {rs_a, re_a, cd_a, fd_a, sa_a};
    assign obs_b = {rs_b, re_b, cd_b, fd_b, sa_b};

    // Reference model: position within the frame, counted in cycles.
    int         m_blank [2] = '{1, 3};
    int         m_pre   [2] = '{4, 1};
    bit         m_act   [2];
    int         m_pos   [2];
    bit         m_fs    [2];
    bit         m_pend  [2];
    bit         m_fd    [2];
    bit         m_ack   [2];
    logic [7:0] m_mem   [2][2][8];

    task automatic model_step(input int c);
        int per, fp;
        bit fire;
        per = m_blank[c] + m_pre[c];
        fp  = 8 * per;
        m_fd[c]  = 1'b0;
        m_ack[c] = 1'b0;
        fire     = 1'b0;
        if (rst) begin
            m_act[c] = 1'b0; m_pos[c] = 0; m_fs[c] = 1'b0; m_pend[c] = 1'b0;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < 8; r++) m_mem[c][b][r] = 8'h00;
            return;
        end
        if (!m_act[c]) begin
            if (en) begin m_act[c] = 1'b1; m_pos[c] = 0; end
        end else if (m_pos[c] % per == per - 1) begin
            if (m_pos[c] / per == 7) begin
                m_fd[c] = 1'b1;
                fire    = m_pend[c] || swap_req;
            end
            if (en) m_pos[c] = (m_pos[c] + 1) % fp;
            else    m_act[c] = 1'b0;
        end else begin
            m_pos[c] = m_pos[c] + 1;
        end
        if (wr_en) m_mem[c][!m_fs[c]][wr_addr] = wr_data;
        if (fire) begin
            m_fs[c] = !m_fs[c]; m_ack[c] = 1'b1; m_pend[c] = 1'b0;
        end else if (swap_req) begin
            m_pend[c] = 1'b1;
        end
    endtask

    function automatic logic [13:0] exp_vec(input int c);
        int per, row, ph;
        per = m_blank[c] + m_pre[c];
        if (!m_act[c]) return {3'd0, 1'b0, 8'h00, m_fd[c], m_ack[c]};
        row = m_pos[c] / per;
        ph  = m_pos[c] % per;
        if (ph >= m_blank[c])
            return {3'(row), 1'b1, m_mem[c][m_fs[c]][row], m_fd[c], m_ack[c]};
        return {3'(row), 1'b0, 8'h00, m_fd[c], m_ack[c]};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00; swap_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vecs++; if (obs_a !== 14'd0) begin errs++; $display("FAIL reset_a got=%h exp=%h", obs_a, 14'd0); end
            vecs++; if (obs_b !== 14'd0) begin errs++; $display("FAIL reset_b got=%h exp=%h", obs_b, 14'd0); end
        end
    endtask

    task automatic test_first_frame();
        int first_en_a = -1, fd_cyc_a = -1, fd_cyc_b = -1;
        rst = 1'b0;
        for (int i = 0; i < 48; i++) begin
            tick();
            vecs++; if (obs_a !== exp_vec(0)) begin errs++; $display("FAIL frame_a cyc=%0d got=%h exp=%h", i, obs_a, exp_vec(0)); end
            vecs++; if (obs_b !== exp_vec(1)) begin errs++; $display("FAIL frame_b cyc=%0d got=%h exp=%h", i, obs_b, exp_vec(1)); end
            if (re_a === 1'b1 && first_en_a < 0) first_en_a = i;
            if (fd_a === 1'b1 && fd_cyc_a < 0) fd_cyc_a = i;
            if (fd_b === 1'b1 && fd_cyc_b < 0) fd_cyc_b = i;
        end
        vecs++; if (first_en_a != 1) begin errs++; $display("FAIL first_row_en got=%0d exp=1", first_en_a); end
        vecs++; if (fd_cyc_a != 40) begin errs++; $display("FAIL frame_done_a_cycle got=%0d exp=40", fd_cyc_a); end
        vecs++; if (fd_cyc_b != 32) begin errs++; $display("FAIL frame_done_b_cycle got=%0d exp=32", fd_cyc_b); end
    endtask

    task automatic test_swap();
        int acks_a = 0;
        bit seen_ack = 1'b0;
        logic [7:0] seen [8];
        for (int r = 0; r < 8; r++) seen[r] = 8'hxx;
        for (int r = 0; r < 8; r++) begin
            wr_en = 1'b1; wr_addr = 3'(r); wr_data = 8'h01 << r;
            tick();
            vecs++; if (obs_a !== exp_vec(0)) begin errs++; $display("FAIL write_a got=%h exp=%h", obs_a, exp_vec(0)); end
            vecs++; if (obs_b !== exp_vec(1)) begin errs++; $display("FAIL write_b got=%h exp=%h", obs_b, exp_vec(1)); end
        end
        wr_en = 1'b0;
        for (int i = 0; i < 90; i++) begin
            swap_req = (i == 2);
            tick();
            vecs++; if (obs_a !== exp_vec(0)) begin errs++; $display("FAIL swap_a cyc=%0d got=%h exp=%h", i, obs_a, exp_vec(0)); end
            vecs++; if (obs_b !== exp_vec(1)) begin errs++; $display("FAIL swap_b cyc=%0d got=%h exp=%h", i, obs_b, exp_vec(1)); end
            if (sa_a === 1'b1) begin acks_a++; seen_ack = 1'b1; end
            if (seen_ack && re_a === 1'b1) seen[rs_a] = cd_a;
        end
        swap_req = 1'b0;
        vecs++; if (acks_a != 1) begin errs++; $display("FAIL swap_ack_count got=%0d exp=1", acks_a); end
        for (int r = 0; r < 8; r++) begin
            vecs++; if (seen[r] !== (8'h01 << r)) begin errs++; $display("FAIL swapped_row%0d got=%h exp=%h", r, seen[r], 8'h01 << r); end
        end
    endtask

    task automatic test_back_to_back();
        int n = 0, acks_a = 0;
        while (!(m_act[0] && m_pos[0] == 39) && n < 100) begin
            tick(); n++;
            vecs++; if (obs_a !== exp_vec(0)) begin errs++; $display("FAIL b2b_wait_a got=%h exp=%h", obs_a, exp_vec(0)); end
        end
        vecs++; if (n >= 100) begin errs++; $display("FAIL b2b_timeout got=%0d exp<100", n); end
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        vecs++; if ({fd_a, sa_a} !== 2'b11) begin errs++; $display("FAIL boundary_swap got=%b exp=11", {fd_a, sa_a}); end
        vecs++; if (obs_b !== exp_vec(1)) begin errs++; $display("FAIL boundary_b got=%h exp=%h", obs_b, exp_vec(1)); end
        for (int i = 0; i < 60; i++) begin
            swap_req = (i == 3 || i == 9 || i == 15);
            tick();
            vecs++; if (obs_a !== exp_vec(0)) begin errs++; $display("FAIL multi_a cyc=%0d got=%h exp=%h", i, obs_a, exp_vec(0)); end
            vecs++; if (obs_b !== exp_vec(1)) begin errs++; $display("FAIL multi_b cyc=%0d got=%h exp=%h", i, obs_b, exp_vec(1)); end
            if (sa_a === 1'b1) acks_a++;
        end
        swap_req = 1'b0;
        vecs++; if (acks_a != 1) begin errs++; $display("FAIL multi_req_acks got=%0d exp=1", acks_a); end
    endtask

    task automatic test_en_drop();
        int n = 0;
        while (!(m_act[0] && m_pos[0] == 17) && n < 100) begin
            tick(); n++;
            vecs++; if (obs_a !== exp_vec(0)) begin errs++; $display("FAIL drop_wait_a got=%h exp=%h", obs_a, exp_vec(0)); end
        end
        vecs++; if (n >= 100) begin errs++; $display("FAIL drop_timeout got=%0d exp<100", n); end
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            vecs++; if (obs_a !== exp_vec(0)) begin errs++; $display("FAIL drop_a cyc=%0d got=%h exp=%h", i, obs_a, exp_vec(0)); end
            vecs++; if (obs_b !== exp_vec(1)) begin errs++; $display("FAIL drop_b cyc=%0d got=%h exp=%h", i, obs_b, exp_vec(1)); end
        end
        vecs++; if ({rs_a, re_a} !== 4'b0000) begin errs++; $display("FAIL drop_idle got=%b exp=0000", {rs_a, re_a}); end
        en = 1'b1;
        tick();
        tick();
        vecs++; if ({rs_a, re_a} !== 4'b0001) begin errs++; $display("FAIL restart got=%b exp=0001", {rs_a, re_a}); end
        vecs++; if (obs_b !== exp_vec(1)) begin errs++; $display("FAIL restart_b got=%h exp=%h", obs_b, exp_vec(1)); end
    endtask

    task automatic test_reset_mid();
        int n = 0, nonzero = 0;
        while (!(m_act[0] && m_pos[0] == 27) && n < 100) begin
            tick(); n++;
            vecs++; if (obs_a !== exp_vec(0)) begin errs++; $display("FAIL rmid_wait_a got=%h exp=%h", obs_a, exp_vec(0)); end
        end
        vecs++; if (n >= 100) begin errs++; $display("FAIL rmid_timeout got=%0d exp<100", n); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vecs++; if (obs_a !== 14'd0) begin errs++; $display("FAIL rmid_a got=%h exp=%h", obs_a, 14'd0); end
        vecs++; if (obs_b !== 14'd0) begin errs++; $display("FAIL rmid_b got=%h exp=%h", obs_b, 14'd0); end
        for (int i = 0; i < 90; i++) begin
            swap_req = (i == 0);
            tick();
            vecs++; if (obs_a !== exp_vec(0)) begin errs++; $display("FAIL rmid_run_a cyc=%0d got=%h exp=%h", i, obs_a, exp_vec(0)); end
            vecs++; if (obs_b !== exp_vec(1)) begin errs++; $display("FAIL rmid_run_b cyc=%0d got=%h exp=%h", i, obs_b, exp_vec(1)); end
            if (cd_a !== 8'h00 || cd_b !== 8'h00) nonzero++;
        end
        swap_req = 1'b0;
        vecs++; if (nonzero != 0) begin errs++; $display("FAIL cleared_buffers got=%0d exp=0", nonzero); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2500; i++) begin
            en       = ($urandom % 16) != 0;
            wr_en    = ($urandom % 3) == 0;
            wr_addr  = 3'($urandom);
            wr_data  = 8'($urandom);
            swap_req = ($urandom % 20) == 0;
            rst      = ($urandom % 400) == 0;
            tick();
            vecs++; if (obs_a !== exp_vec(0)) begin errs++; $display("FAIL rand_a cyc=%0d got=%h exp=%h", i, obs_a, exp_vec(0)); end
            vecs++; if (obs_b !== exp_vec(1)) begin errs++; $display("FAIL rand_b cyc=%0d got=%h exp=%h", i, obs_b, exp_vec(1)); end
        end
        rst = 1'b0; wr_en = 1'b0; swap_req = 1'b0; en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_swap();
        test_back_to_back();
        test_en_drop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
